// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// register offsets and status-register bit positions.
package uart_tx_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] TXD_OFS  = 32'h0;
    localparam logic [31:0] UCON_OFS = 32'h8;

    localparam int UCON_IEN     = 0;
    localparam int UCON_DRAINED = 1;
    localparam int UCON_FULL    = 2;
    localparam int UCON_OVF     = 3;

    // The status field is 4 bits wide; deeper FIFOs report 15 when fuller.
    function automatic logic [3:0] sat_count(input logic [6:0] c);
        return (c > 7'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_port_if.sv
// CPU data-bus view of the UART transmitter.
interface uart_tx_port_if;
    // wr commits at the rising edge on which it is high; rd has no side
    // effects and rdata follows rd/addr combinationally.
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_port_sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH.
module uart_tx_port_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is queued.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: TXD pushes bytes into a FIFO which an
// 8N1 serialiser drains; UCON holds irq enable, overflow and drain status.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int          CLK_FREQ   = 100000000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h40000018
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_port_if.slave bus,
    output logic          tx,
    output logic          irq,
    output tx_state_e     state_dbg
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    tx_state_e        state, state_n;
    logic [CNT_W-1:0] baud_cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shift, shift_n;
    logic             tx_n;
    logic             pop;
    logic             baud_last;

    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic             ien;
    logic             ovf;
    logic             txd_hit, ucon_hit;
    logic             txd_wr, ucon_wr;
    logic             drained;
    logic             unused_wdata;

    assign txd_hit      = (bus.addr == BASE_ADDR + TXD_OFS);
    assign ucon_hit     = (bus.addr == BASE_ADDR + UCON_OFS);
    assign txd_wr       = bus.wr && txd_hit;
    assign ucon_wr      = bus.wr && ucon_hit;
    assign drained      = fifo_empty && (state == IDLE);
    assign baud_last    = (baud_cnt == CNT_W'(DIV - 1));
    assign state_dbg    = state;
    assign unused_wdata = ^bus.wdata[31:8];

    uart_tx_port_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_sync_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (txd_wr && !fifo_full),
        .pop   (pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= cnt_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            tx       <= tx_n;
        end
    end

    // tx_n is the line level for the cycle after this edge, so tx is a flop.
    always_comb begin
        state_n = state;
        cnt_n   = baud_cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        tx_n    = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_head;
                    cnt_n   = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    tx_n    = shift[0];
                end else begin
                    cnt_n = baud_cnt + CNT_W'(1);
                    tx_n  = 1'b0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        tx_n    = shift[1];
                    end
                end else begin
                    cnt_n = baud_cnt + CNT_W'(1);
                    tx_n  = shift[0];
                end
            end
            STOP: begin
                if (baud_last) begin
                    cnt_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_head;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A drop in the same cycle as a clear leaves ovf set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ien <= 1'b0;
            ovf <= 1'b0;
            irq <= 1'b0;
        end else begin
            irq <= ien && drained;
            if (ucon_wr) begin
                ien <= bus.wdata[0];
                if (bus.wdata[1]) ovf <= 1'b0;
            end
            if (txd_wr && fifo_full) ovf <= 1'b1;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && ucon_hit) begin
            bus.rdata[UCON_IEN]     = ien;
            bus.rdata[UCON_DRAINED] = drained;
            bus.rdata[UCON_FULL]    = fifo_full;
            bus.rdata[UCON_OVF]     = ovf;
            bus.rdata[7:4]          = sat_count(7'(fifo_count));
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with DIV=10 and a 4-entry FIFO.
module tb_uart_tx_port;
    import uart_tx_port_pkg::*;

    localparam int          CLK_FREQ   = 100;
    localparam int          BAUD       = 10;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] BASE       = 32'h40000018;
    localparam logic [31:0] TXD        = BASE;
    localparam logic [31:0] UCON       = BASE + 32'h8;

    logic      clk = 1'b0;
    logic      reset = 1'b1;
    logic      tx;
    logic      irq;
    tx_state_e state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_tx_port_if bus ();

    uart_tx_port #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .tx        (tx),
        .irq       (irq),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.rd   = 1'b1;
        bus.addr = a;
        #1;
        d        = bus.rdata;
        bus.rd   = 1'b0;
        bus.addr = '0;
    endtask

    // Expected line level c cycles into an 8N1 frame of 10 cycles per bit.
    function automatic logic frame_bit(input logic [7:0] b, input int c);
        int slot;
        slot = c / 10;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic test_reset();
        logic [31:0] rd_val;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        vec_cnt++;
        if (tx !== 1'b1) begin err_cnt++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vec_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL reset_irq: got %b expected 0", irq); end
        vec_cnt++;
        if (state_dbg !== IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
        bus_read(UCON, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h2) begin err_cnt++; $display("FAIL reset_ucon: got %h expected 00000002", rd_val); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd_val;
        bus_write(TXD, 32'hA5);
        for (int c = 0; c < 100; c++) begin
            tick();
            vec_cnt++;
            if (tx !== frame_bit(8'hA5, c)) begin
                err_cnt++;
                $display("FAIL single_a5 cyc %0d: got %b expected %b", c, tx, frame_bit(8'hA5, c));
            end
        end
        tick();
        vec_cnt++;
        if (state_dbg !== IDLE) begin err_cnt++; $display("FAIL single_idle: got %0d expected %0d", state_dbg, IDLE); end
        vec_cnt++;
        if (tx !== 1'b1) begin err_cnt++; $display("FAIL single_tx_idle: got %b expected 1", tx); end
        bus_read(UCON, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h2) begin err_cnt++; $display("FAIL single_drained: got %h expected 00000002", rd_val); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [5];
        logic [31:0] rd_val;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h3C; bytes[3] = 8'h80; bytes[4] = 8'hFF;
        fork
            begin
                for (int i = 0; i < 5; i++) bus_write(TXD, {24'h0, bytes[i]});
                bus_read(UCON, rd_val);
                vec_cnt++;
                if (rd_val !== 32'h44) begin err_cnt++; $display("FAIL b2b_full: got %h expected 00000044", rd_val); end
                bus_write(TXD, 32'h55);
                bus_read(UCON, rd_val);
                vec_cnt++;
                if (rd_val !== 32'h4C) begin err_cnt++; $display("FAIL b2b_ovf_set: got %h expected 0000004c", rd_val); end
                bus_write(UCON, 32'h2);
                bus_read(UCON, rd_val);
                vec_cnt++;
                if (rd_val !== 32'h44) begin err_cnt++; $display("FAIL b2b_ovf_clr: got %h expected 00000044", rd_val); end
            end
            begin
                tick();
                for (int k = 0; k < 5; k++) begin
                    for (int c = 0; c < 100; c++) begin
                        tick();
                        vec_cnt++;
                        if (tx !== frame_bit(bytes[k], c)) begin
                            err_cnt++;
                            $display("FAIL b2b_frame%0d cyc %0d: got %b expected %b", k, c, tx, frame_bit(bytes[k], c));
                        end
                    end
                end
            end
        join
        for (int c = 0; c < 20; c++) begin
            tick();
            vec_cnt++;
            if (tx !== 1'b1) begin err_cnt++; $display("FAIL b2b_no_sixth cyc %0d: got %b expected 1", c, tx); end
        end
        bus_read(UCON, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h2) begin err_cnt++; $display("FAIL b2b_end_ucon: got %h expected 00000002", rd_val); end
    endtask

    task automatic test_irq();
        bus_write(UCON, 32'h1);
        tick();
        vec_cnt++;
        if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_idle_en: got %b expected 1", irq); end
        bus_write(TXD, 32'h3C);
        for (int c = 0; c <= 100; c++) begin
            tick();
            vec_cnt++;
            if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_in_frame cyc %0d: got %b expected 0", c, irq); end
            if (c < 100) begin
                vec_cnt++;
                if (tx !== frame_bit(8'h3C, c)) begin
                    err_cnt++;
                    $display("FAIL irq_frame cyc %0d: got %b expected %b", c, tx, frame_bit(8'h3C, c));
                end
            end
        end
        vec_cnt++;
        if (state_dbg !== IDLE) begin err_cnt++; $display("FAIL irq_back_idle: got %0d expected %0d", state_dbg, IDLE); end
        tick();
        vec_cnt++;
        if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_drained: got %b expected 1", irq); end
        bus_write(UCON, 32'h0);
        vec_cnt++;
        if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_disable_lag: got %b expected 1", irq); end
        tick();
        vec_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_disabled: got %b expected 0", irq); end
    endtask

    task automatic test_decode();
        logic [31:0] rd_val;
        bus_read(BASE + 32'h4, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h0) begin err_cnt++; $display("FAIL dec_base4: got %h expected 00000000", rd_val); end
        bus.rd   = 1'b0;
        bus.addr = UCON;
        #1;
        vec_cnt++;
        if (bus.rdata !== 32'h0) begin err_cnt++; $display("FAIL dec_no_rd: got %h expected 00000000", bus.rdata); end
        bus.addr = '0;
        bus_read(TXD, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h0) begin err_cnt++; $display("FAIL dec_read_txd: got %h expected 00000000", rd_val); end
        bus_read(UCON ^ 32'h100, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h0) begin err_cnt++; $display("FAIL dec_ucon_alias: got %h expected 00000000", rd_val); end
        bus_write(BASE + 32'h4, 32'h77);
        bus_write(TXD ^ 32'h1000, 32'h77);
        for (int c = 0; c < 30; c++) begin
            tick();
            vec_cnt++;
            if (tx !== 1'b1) begin err_cnt++; $display("FAIL dec_no_push cyc %0d: got %b expected 1", c, tx); end
        end
        bus_read(UCON, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h2) begin err_cnt++; $display("FAIL dec_ucon: got %h expected 00000002", rd_val); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd_val;
        bus_write(TXD, 32'h00);
        bus_write(TXD, 32'hFF);
        bus_write(TXD, 32'h81);
        repeat (33) tick();
        vec_cnt++;
        if (tx !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_bit2: got %b expected 0", tx); end
        bus_read(UCON, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h20) begin err_cnt++; $display("FAIL rst_mid_count: got %h expected 00000020", rd_val); end
        #1 reset = 1'b1;
        #1;
        vec_cnt++;
        if (tx !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
        vec_cnt++;
        if (state_dbg !== IDLE) begin err_cnt++; $display("FAIL rst_mid_state: got %0d expected %0d", state_dbg, IDLE); end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        bus_read(UCON, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h2) begin err_cnt++; $display("FAIL rst_mid_ucon: got %h expected 00000002", rd_val); end
        for (int c = 0; c < 150; c++) begin
            tick();
            vec_cnt++;
            if (tx !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_silent cyc %0d: got %b expected 1", c, tx); end
        end
    endtask

    task automatic test_stop_edge_write();
        logic [31:0] rd_val;
        bus_write(TXD, 32'hC3);
        for (int c = 0; c < 100; c++) begin
            tick();
            vec_cnt++;
            if (tx !== frame_bit(8'hC3, c)) begin
                err_cnt++;
                $display("FAIL edge_first cyc %0d: got %b expected %b", c, tx, frame_bit(8'hC3, c));
            end
        end
        bus_write(TXD, 32'h5A);
        vec_cnt++;
        if (state_dbg !== IDLE) begin err_cnt++; $display("FAIL edge_idle: got %0d expected %0d", state_dbg, IDLE); end
        vec_cnt++;
        if (tx !== 1'b1) begin err_cnt++; $display("FAIL edge_tx_idle: got %b expected 1", tx); end
        for (int c = 0; c < 100; c++) begin
            tick();
            vec_cnt++;
            if (tx !== frame_bit(8'h5A, c)) begin
                err_cnt++;
                $display("FAIL edge_second cyc %0d: got %b expected %b", c, tx, frame_bit(8'h5A, c));
            end
        end
        tick();
        bus_read(UCON, rd_val);
        vec_cnt++;
        if (rd_val !== 32'h2) begin err_cnt++; $display("FAIL edge_drained: got %h expected 00000002", rd_val); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_irq();
        test_decode();
        test_reset_mid_frame();
        test_stop_edge_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmit responder on the CPU data bus (rd/wr/addr/wdata/rdata), the serialising end of the CPU's byte-output path.
- CPU stores bytes to a TX data register; the block queues them in a small FIFO and shifts them out as 8N1 frames on a serial pin.
- Provides a status register and a level interrupt ("transmitter drained"), OR-combined with the other read-data sources and IRQ lines at the top level.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate; DIV = CLK_FREQ/BAUD cycles per bit (integer divide, DIV >= 2).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- BASE_ADDR, 32'h40000018, address of TXD; status register UCON at BASE_ADDR+8.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe.
- addr  in  32  bus byte address.
- wdata  in  32  bus write data; only [7:0] used.
- rdata  out  32  read data, combinational; 0 unless rd=1 and addr hits UCON.
- tx  out  1  serial output, idle high.
- irq  out  1  registered level interrupt.

Behaviour:
- Reset (async, active-high): FIFO empty, pointers/count 0, state IDLE, tx=1, irq=0, ovf=0, ien=0, baud counter 0, bit index 0.
- Decode: TXD hit = addr==BASE_ADDR; UCON hit = addr==BASE_ADDR+8; exact word compare, no aliasing.
- Write TXD: if FIFO not full (count sampled before this cycle's pop), push wdata[7:0] at the edge. If full, drop and set ovf=1. Same-cycle push and pop on a non-full FIFO both occur; count unchanged.
- Write UCON: ien <= wdata[0]; ovf <= 0 if wdata[1]=1 (write-1-to-clear).
- Read UCON: rdata = {24'b0, count[3:0], ovf, full, empty_and_idle, ien}; bit0=ien, bit1=drained (FIFO empty and state IDLE), bit2=full, bit3=ovf, [7:4]=count saturated at 15. Reads have no side effects. Reading TXD returns 0.
- FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: tx=1; if FIFO non-empty, pop head into shift register, baud counter 0, go START. First byte: wr at edge N, pop at edge N+1, tx=0 from N+1.
  - START: tx=0 for DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, DIV cycles per bit; after bit 7 go STOP.
  - STOP: tx=1 for DIV cycles; then if FIFO non-empty pop and go directly to START (back-to-back, no idle gap), else IDLE.
- Frame length exactly 10*DIV cycles; baud counter counts 0..DIV-1 and wraps.
- tx is driven from a flop (glitch-free).
- irq registered: irq <= ien & drained each cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Reset mid-frame aborts immediately: tx=1, queued data discarded.

Decomposition:
- Shared package: UCON bit positions, state encoding (IDLE/START/DATA/STOP), register offsets (TXD=0, UCON=8).
- One sub-module, sync_fifo (width 8, depth FIFO_DEPTH; push/pop/full/empty/count). FSM, baud counter and bus decode stay in uart_tx_port.

Test Plan (CLK_FREQ=100, BAUD=10, DIV=10, FIFO_DEPTH=4):
- Write 0xA5 to TXD from idle -> tx low from edge N+1 for 10 cycles, then 1,0,1,0,0,1,0,1 each 10 cycles, then high 10 cycles; UCON bit1=1 after the stop bit.
- Write 5 bytes back-to-back from idle -> first popped at N+1, remaining 4 fill FIFO, none dropped, ovf=0. A 6th write while 4 are queued -> dropped, ovf=1. Write UCON 0x2 -> ovf=0. Exactly 5 frames emitted with no idle gap between stop and next start.
- ien=1, one byte sent -> irq=0 during frame, irq=1 one cycle after FSM returns to IDLE. Write UCON 0 -> irq=0 next cycle.
- Read with addr=BASE_ADDR+4, or rd=0 with addr=UCON -> rdata=0. Read TXD -> 0.
- Assert reset in the 3rd data bit with 2 bytes queued -> tx=1 immediately, UCON reads 0x2 after release, no further frames.
- Write to TXD on the exact cycle STOP ends with FIFO empty -> byte accepted, next frame starts one cycle after IDLE is entered, with no lost byte.
